elevator_scheduler: RTL and testbench

//  Parametrised N-floor elevator car controller; successor to the 6-floor direction FSM.

---
 rtl/elevator_scheduler.sv | 150 +++++++++++++++
 tb/tb_elevator_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: N-floor SCAN car controller with travel and door-dwell timing.
// Define DOOR_HOLD_EN to add the DoorHold input that extends the door dwell.
module elevator_scheduler #(
    parameter int unsigned N_FLOORS      = 6,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [N_FLOORS-1:0] reqIn,
    input  logic                Stop,
`ifdef DOOR_HOLD_EN
    input  logic                DoorHold,
`endif
    output logic [N_FLOORS-1:0] currentFloor,
    output logic [N_FLOORS-1:0] pending,
    output logic                Up,
    output logic                Down,
    output logic                Moving,
    output logic                DoorOpen
);

    localparam int unsigned CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] TLOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DLOAD = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoorOpen} state_e;

    state_e              state_q, state_d;
    logic [N_FLOORS-1:0] floor_q, floor_d;
    logic [N_FLOORS-1:0] req_q, req_d;
    logic                up_q, up_d;
    logic [CW-1:0]       tcnt_q, tcnt_d;
    logic [CW-1:0]       dcnt_q, dcnt_d;
    logic                moving_q, door_q;

    logic [N_FLOORS-1:0] pend, clr, below_mask, above_mask;
    logic                above, below, here, ahead, behind, hold;

`ifdef DOOR_HOLD_EN
    assign hold = DoorHold;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        pend       = req_q | reqIn;
        below_mask = floor_q - N_FLOORS'(1);
        above_mask = ~(floor_q | below_mask);
        above      = |(pend & above_mask);
        below      = |(pend & below_mask);
        here       = |(pend & floor_q);
        ahead      = up_q ? above : below;
        behind     = up_q ? below : above;

        state_d = state_q;
        floor_d = floor_q;
        up_d    = up_q;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;

        unique case (state_q)
            StIdle: begin
                if (!Stop) begin
                    if (here) begin
                        state_d = StDoorOpen;
                        dcnt_d  = DLOAD;
                    end else if (ahead) begin
                        state_d = up_q ? StMoveUp : StMoveDown;
                        tcnt_d  = TLOAD;
                    end else if (behind) begin
                        state_d = up_q ? StMoveDown : StMoveUp;
                        up_d    = ~up_q;
                        tcnt_d  = TLOAD;
                    end
                end
            end
            StMoveUp, StMoveDown: begin
                if (!Stop) begin
                    if (tcnt_q == '0) begin
                        floor_d = (state_q == StMoveUp) ? (floor_q << 1) : (floor_q >> 1);
                        // A call raised on the arrival edge for the new floor still stops the car.
                        if (|(pend & floor_d)) begin
                            state_d = StDoorOpen;
                            dcnt_d  = DLOAD;
                        end else begin
                            tcnt_d = TLOAD;
                        end
                    end else begin
                        tcnt_d = tcnt_q - CW'(1);
                    end
                end
            end
            StDoorOpen: begin
                if (!Stop) begin
                    if (here || hold) begin
                        dcnt_d = DLOAD;
                    end else if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - CW'(1);
                    end else if (ahead) begin
                        state_d = up_q ? StMoveUp : StMoveDown;
                        tcnt_d  = TLOAD;
                    end else if (behind) begin
                        state_d = up_q ? StMoveDown : StMoveUp;
                        up_d    = ~up_q;
                        tcnt_d  = TLOAD;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Calls for the floor the door is (or stays) open at are served immediately.
        clr   = (state_d == StDoorOpen) ? floor_d : '0;
        req_d = pend & ~clr;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            floor_q  <= N_FLOORS'(1);
            req_q    <= '0;
            up_q     <= 1'b1;
            tcnt_q   <= '0;
            dcnt_q   <= '0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            req_q    <= req_d;
            up_q     <= up_d;
            tcnt_q   <= tcnt_d;
            dcnt_q   <= dcnt_d;
            moving_q <= (state_d == StMoveUp) || (state_d == StMoveDown);
            door_q   <= (state_d == StDoorOpen);
        end
    end

    assign currentFloor = floor_q;
    assign pending      = req_q;
    assign Up           = up_q;
    assign Down         = ~up_q;
    assign Moving       = moving_q;
    assign DoorOpen     = door_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed vector table, reset/hold sequences and random traffic
// checked against an integer-floor reference model.
module tb_elevator_scheduler;

    localparam int N = 6;
    localparam int T = 4;
    localparam int D = 3;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic         Clock;
    logic         Reset;
    logic [N-1:0] reqIn;
    logic         Stop;
    logic         DoorHold;
    logic [N-1:0] currentFloor;
    logic [N-1:0] pending;
    logic         Up, Down, Moving, DoorOpen;

    int passed = 0;
    int total  = 0;

    // Reference model: integer floor, signed heading, cycles-remaining timer.
    int           m_floor, m_head, m_mode, m_rem;
    logic [N-1:0] m_calls;

    elevator_scheduler #(
        .N_FLOORS     (N),
        .TRAVEL_CYCLES(T),
        .DOOR_CYCLES  (D)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .reqIn       (reqIn),
        .Stop        (Stop),
`ifdef DOOR_HOLD_EN
        .DoorHold    (DoorHold),
`endif
        .currentFloor(currentFloor),
        .pending     (pending),
        .Up          (Up),
        .Down        (Down),
        .Moving      (Moving),
        .DoorOpen    (DoorOpen)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [N-1:0] req;
        logic         stop;
        int           ncyc;
        logic [N-1:0] floor;
        logic [N-1:0] pend;
        logic         up;
        logic         mov;
        logic         door;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_floor = 0;
        m_head  = 1;
        m_mode  = M_IDLE;
        m_rem   = 0;
        m_calls = '0;
    endtask

    task automatic choose(input logic [N-1:0] c);
        int ahead;
        int behind;
        ahead  = 0;
        behind = 0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) begin
                if ((i - m_floor) * m_head > 0) ahead++;
                else if ((i - m_floor) * m_head < 0) behind++;
            end
        end
        if (ahead > 0) begin
            m_mode = M_MOVE;
            m_rem  = T;
        end else if (behind > 0) begin
            m_head = -m_head;
            m_mode = M_MOVE;
            m_rem  = T;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic stop, input logic hold);
        logic [N-1:0] c;
        c = m_calls | req;
        if (!stop) begin
            if (m_mode == M_IDLE) begin
                if (c[m_floor]) begin
                    m_mode = M_DOOR;
                    m_rem  = D;
                end else begin
                    choose(c);
                end
            end else if (m_mode == M_MOVE) begin
                if (m_rem == 1) begin
                    m_floor = m_floor + m_head;
                    if (c[m_floor]) begin
                        m_mode = M_DOOR;
                        m_rem  = D;
                    end else begin
                        m_rem = T;
                    end
                end else begin
                    m_rem--;
                end
            end else begin
                if (c[m_floor] || hold) m_rem = D;
                else if (m_rem > 1) m_rem--;
                else choose(c);
            end
        end
        if (m_mode == M_DOOR) c[m_floor] = 1'b0;
        m_calls = c;
    endtask

    task automatic step(input logic [N-1:0] req, input logic stop, input logic hold);
        reqIn    = req;
        Stop     = stop;
        DoorHold = hold;
        model_step(req, stop, hold);
        @(posedge Clock);
        #1;
        reqIn    = '0;
        Stop     = 1'b0;
        DoorHold = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] ef;
        ef = '0;
        ef[m_floor] = 1'b1;
        chk({tag, " floor"}, 32'(currentFloor), 32'(ef));
        chk({tag, " pending"}, 32'(pending), 32'(m_calls));
        chk({tag, " up"}, 32'(Up), 32'(m_head == 1));
        chk({tag, " down"}, 32'(Down), 32'(m_head == -1));
        chk({tag, " moving"}, 32'(Moving), 32'(m_mode == M_MOVE));
        chk({tag, " door"}, 32'(DoorOpen), 32'(m_mode == M_DOOR));
        chk({tag, " onehot"}, 32'($onehot(currentFloor)), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " floor"}, 32'(currentFloor), 32'd1);
        chk({tag, " pending"}, 32'(pending), 32'd0);
        chk({tag, " up"}, 32'(Up), 32'd1);
        chk({tag, " down"}, 32'(Down), 32'd0);
        chk({tag, " moving"}, 32'(Moving), 32'd0);
        chk({tag, " door"}, 32'(DoorOpen), 32'd0);
    endtask

    initial begin
        logic [N-1:0] r;
        logic         s;
        logic         h;

        // req, stop, cycles, floor, pending, up, moving, door
        vecs[0]  = '{6'b000001, 1'b0, 1,  6'b000001, 6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{6'b000000, 1'b0, 2,  6'b000001, 6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{6'b000000, 1'b0, 1,  6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{6'b010000, 1'b0, 1,  6'b000001, 6'b010000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{6'b000000, 1'b0, 3,  6'b000001, 6'b010000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{6'b000000, 1'b0, 1,  6'b000010, 6'b010000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{6'b000000, 1'b0, 11, 6'b001000, 6'b010000, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{6'b000000, 1'b0, 1,  6'b010000, 6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{6'b000000, 1'b0, 3,  6'b010000, 6'b000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{6'b000100, 1'b0, 1,  6'b010000, 6'b000100, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{6'b000000, 1'b1, 3,  6'b010000, 6'b000100, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{6'b000000, 1'b0, 3,  6'b010000, 6'b000100, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{6'b000000, 1'b0, 1,  6'b001000, 6'b000100, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{6'b000000, 1'b0, 4,  6'b000100, 6'b000000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{6'b000000, 1'b1, 5,  6'b000100, 6'b000000, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{6'b000000, 1'b0, 2,  6'b000100, 6'b000000, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{6'b000000, 1'b0, 1,  6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{6'b100001, 1'b0, 1,  6'b000100, 6'b100001, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{6'b000000, 1'b0, 7,  6'b000010, 6'b100001, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{6'b000000, 1'b0, 1,  6'b000001, 6'b100000, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{6'b000000, 1'b0, 3,  6'b000001, 6'b100000, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{6'b000000, 1'b0, 20, 6'b100000, 6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[22] = '{6'b000000, 1'b0, 3,  6'b100000, 6'b000000, 1'b1, 1'b0, 1'b0};
        vecs[23] = '{6'b100000, 1'b0, 1,  6'b100000, 6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[24] = '{6'b100000, 1'b0, 1,  6'b100000, 6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[25] = '{6'b000000, 1'b0, 2,  6'b100000, 6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[26] = '{6'b000000, 1'b0, 1,  6'b100000, 6'b000000, 1'b1, 1'b0, 1'b0};

        Reset    = 1'b0;
        reqIn    = '0;
        Stop     = 1'b0;
        DoorHold = 1'b0;
        model_reset();
        #12;
        check_reset_vals("por");
        Reset = 1'b1;
        @(posedge Clock);
        #1;

        for (int i = 0; i < 27; i++) begin
            for (int k = 0; k < vecs[i].ncyc; k++)
                step((k == 0) ? vecs[i].req : '0, vecs[i].stop, 1'b0);
            chk($sformatf("row%0d floor", i), 32'(currentFloor), 32'(vecs[i].floor));
            chk($sformatf("row%0d pending", i), 32'(pending), 32'(vecs[i].pend));
            chk($sformatf("row%0d up", i), 32'(Up), 32'(vecs[i].up));
            chk($sformatf("row%0d down", i), 32'(Down), 32'(!vecs[i].up));
            chk($sformatf("row%0d moving", i), 32'(Moving), 32'(vecs[i].mov));
            chk($sformatf("row%0d door", i), 32'(DoorOpen), 32'(vecs[i].door));
        end

        // Async reset between edges while moving down with calls latched.
        step(6'b001001, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("pre_reset moving", 32'(Moving), 32'd1);
        chk("pre_reset pending", 32'(pending), 32'(6'b001001));
        #2;
        Reset = 1'b0;
        #1;
        check_reset_vals("midmove_reset");
        model_reset();
        #2;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_model("post_reset");

`ifdef DOOR_HOLD_EN
        step(6'b000001, 1'b0, 1'b0);
        chk("hold entry door", 32'(DoorOpen), 32'd1);
        for (int k = 0; k < 7; k++) begin
            step('0, 1'b0, (k < 5) ? 1'b1 : 1'b0);
            chk($sformatf("hold cyc%0d door", k), 32'(DoorOpen), 32'd1);
        end
        step('0, 1'b0, 1'b0);
        chk("hold release door", 32'(DoorOpen), 32'd0);
        check_model("hold_end");
`endif

        for (int c = 0; c < 2500; c++) begin
            r = '0;
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 15) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
            s = ($urandom_range(0, 15) == 0);
            h = 1'b0;
`ifdef DOOR_HOLD_EN
            h = ($urandom_range(0, 7) == 0);
`endif
            step(r, s, h);
            check_model($sformatf("rand%0d", c));
            chk($sformatf("rand%0d excl", c), 32'(Up ^ Down), 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
